// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters driving a shared 4:1 data mux select.
// Optional tenure limit enabled by defining MUX_ARB_HOLD_LIMIT_EN (uses MAX_HOLD).
module mux_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] in,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       valid,
   output logic       out
);

   localparam int unsigned N  = 4;
   localparam int unsigned IW = 2;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("mux_rr_arbiter: MAX_HOLD must be in 2..255");
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_n;
   logic [IW-1:0] ptr, ptr_n;
   logic [N-1:0]  gnt_n;
   logic [IW-1:0] sel_n;
   logic          valid_n;
   logic [IW:0]   win;
   logic          rel;
`ifdef MUX_ARB_HOLD_LIMIT_EN
   localparam int unsigned CW = 8;
   logic [CW-1:0] cnt, cnt_n;
   logic          others;
   logic          expire;
`endif

   // First requester in search order starting at p; returns {found, index}.
   function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
      logic [IW:0]   res;
      logic [IW-1:0] idx;
      res = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = p + IW'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         gnt   <= '0;
         sel   <= '0;
         valid <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         valid <= valid_n;
`ifdef MUX_ARB_HOLD_LIMIT_EN
         cnt   <= cnt_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      gnt_n   = gnt;
      sel_n   = sel;
      valid_n = valid;
      win     = '0;
      rel     = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      cnt_n   = cnt;
      others  = 1'b0;
      expire  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (|req) begin
               win     = pick(req, ptr);
               state_n = GRANT;
               gnt_n   = N'(1) << win[IW-1:0];
               sel_n   = win[IW-1:0];
               valid_n = 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
               cnt_n   = '0;
`endif
            end
         end
         GRANT: begin
            rel = !req[sel];
`ifdef MUX_ARB_HOLD_LIMIT_EN
            others = |(req & ~gnt);
            expire = (cnt == CW'(MAX_HOLD - 1));
            cnt_n  = cnt + CW'(1);
            // Expiry with nobody waiting: owner keeps the grant, tenure restarts.
            if (expire && !others) cnt_n = '0;
            if (expire && others) rel = 1'b1;
`endif
            if (rel) begin
               ptr_n = sel + IW'(1);
               // Owner is masked so a preempted owner cannot win its own handover.
               win   = pick(req & ~gnt, ptr_n);
               if (win[IW]) begin
                  gnt_n   = N'(1) << win[IW-1:0];
                  sel_n   = win[IW-1:0];
                  valid_n = 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
                  cnt_n   = '0;
`endif
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  valid_n = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign out = valid ? in[sel] : 1'b0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench for mux_rr_arbiter (MAX_HOLD=4).
// Hold-limit steps follow MUX_ARB_HOLD_LIMIT_EN when it is defined.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] in;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       valid;
   logic       out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      tag;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       out;
   } exp_t;

   exp_t sb[$];

   mux_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .in   (in),
      .gnt  (gnt),
      .sel  (sel),
      .valid(valid),
      .out  (out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   // owner < 0 means no grant; idle_sel is the held select value in that case.
   task automatic push(input string tag, input int owner, input logic [1:0] idle_sel);
      exp_t e;
      logic [3:0] d;
      d       = in;
      e.tag   = tag;
      e.gnt   = (owner >= 0) ? (4'd1 << owner) : 4'd0;
      e.sel   = (owner >= 0) ? 2'(owner) : idle_sel;
      e.valid = (owner >= 0);
      e.out   = (owner >= 0) ? d[owner] : 1'b0;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: empty queue at check, got nothing expected an entry");
         return;
      end
      e = sb.pop_front();
      checks += 4;
      assert (gnt === e.gnt) else begin
         errors++;
         $error("FAIL %s gnt: got %b expected %b", e.tag, gnt, e.gnt);
      end
      assert (sel === e.sel) else begin
         errors++;
         $error("FAIL %s sel: got %0d expected %0d", e.tag, sel, e.sel);
      end
      assert (valid === e.valid) else begin
         errors++;
         $error("FAIL %s valid: got %b expected %b", e.tag, valid, e.valid);
      end
      assert (out === e.out) else begin
         errors++;
         $error("FAIL %s out: got %b expected %b", e.tag, out, e.out);
      end
   endtask

   task automatic step(input string tag, input logic [3:0] r, input logic [3:0] d,
                       input int owner, input logic [1:0] idle_sel);
      req = r;
      in  = d;
      push(tag, owner, idle_sel);
      @(posedge clk);
      #1;
      check();
   endtask

   initial begin
      int hold_seq[11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

      rst_n = 1'b0;
      req   = 4'b0000;
      in    = 4'b0000;
      #2;
      push("reset", -1, 2'd0);
      check();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle with no requests
      for (int i = 0; i < 5; i++) step("idle", 4'b0000, 4'b1111, -1, 2'd0);

      // All requesting, each owner holds two cycles then drops
      step("rr0a", 4'b1111, 4'b0101, 0, 2'd0);
      step("rr0b", 4'b1111, 4'b0101, 0, 2'd0);
      step("rr1a", 4'b1110, 4'b0101, 1, 2'd0);
      step("rr1b", 4'b1111, 4'b0101, 1, 2'd0);
      step("rr2a", 4'b1101, 4'b1010, 2, 2'd0);
      step("rr2b", 4'b1111, 4'b0101, 2, 2'd0);
      step("rr3a", 4'b1011, 4'b1010, 3, 2'd0);
      step("rr3b", 4'b1111, 4'b1000, 3, 2'd0);
      step("rr0c", 4'b0111, 4'b0001, 0, 2'd0);
      step("rrend", 4'b0000, 4'b0001, -1, 2'd0);

      // Single requester 2, data through the mux, sel held after release
      step("r2in1", 4'b0100, 4'b0100, 2, 2'd0);
      step("r2in0", 4'b0100, 4'b1011, 2, 2'd0);
      step("r2rel", 4'b0000, 4'b1011, -1, 2'd2);
      step("r2idle", 4'b0000, 4'b1111, -1, 2'd2);

      // Owner 3 hands over to 0 at the same edge (pointer wrap)
      step("w3", 4'b1000, 4'b1000, 3, 2'd2);
      step("w3to0", 4'b0001, 4'b1000, 0, 2'd2);
      step("w0hold", 4'b0011, 4'b0001, 0, 2'd2);
      step("w0to1", 4'b0010, 4'b0010, 1, 2'd2);
      step("wend", 4'b0000, 4'b0010, -1, 2'd1);

      // Reset mid-grant of owner 2
      step("m2", 4'b0100, 4'b0100, 2, 2'd1);
      rst_n = 1'b0;
      #1;
      push("mrst", -1, 2'd0);
      check();
      req = 4'b1111;
      @(posedge clk);
      #1;
      push("mrsthold", -1, 2'd0);
      check();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      push("mrstrel", -1, 2'd0);
      check();
      step("post0a", 4'b1111, 4'b0001, 0, 2'd0);
      step("post0b", 4'b1111, 4'b0001, 0, 2'd0);
      step("postend", 4'b0000, 4'b0001, -1, 2'd0);

      // Tenure behaviour with two requesters
      step("h0", 4'b0001, 4'b0001, 0, 2'd0);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      foreach (hold_seq[i]) step("hlim", 4'b0011, 4'b0001, hold_seq[i], 2'd0);
      for (int i = 0; i < 8; i++) step("hsolo", 4'b0001, 4'b0001, 0, 2'd0);
`else
      for (int i = 0; i < 10; i++) step("hnolim", 4'b0011, 4'b0001, 0, 2'd0);
      step("hrel", 4'b0010, 4'b0010, hold_seq[3], 2'd0);
`endif

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
